// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory between the I-cache and D-cache.
// One memory transaction in flight at a time; ready is forwarded only to the owner.
//
// state   | meaning
// IDLE    | no owner; requests sampled at each edge
// SERVE_I | I port owns memory, waiting for mem_ready
// SERVE_D | D port owns memory, waiting for mem_ready
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_d,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state;
  logic   last_grant_d;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req  = i_mem_read | i_mem_write;
  assign d_req  = d_mem_read | d_mem_write;
  // On a tie the port that did not win last time goes first
  assign pick_d = d_req & (~i_req | ~last_grant_d);

  always_ff @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      grant_d      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= SERVE_D;
            last_grant_d <= 1'b1;
            mem_write    <= d_mem_write;
            mem_read     <= ~d_mem_write;
            mem_addr     <= d_mem_addr;
            mem_wdata    <= d_mem_wdata;
            grant_d      <= 1'b1;
            busy         <= 1'b1;
          end else if (i_req) begin
            state        <= SERVE_I;
            last_grant_d <= 1'b0;
            mem_write    <= i_mem_write;
            mem_read     <= ~i_mem_write;
            mem_addr     <= i_mem_addr;
            mem_wdata    <= i_mem_wdata;
            grant_d      <= 1'b0;
            busy         <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            grant_d   <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_mem_ready = (state == SERVE_I) & mem_ready;
  assign d_mem_ready = (state == SERVE_D) & mem_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] WI = {4{32'h1111_2222}};
  localparam logic [DW-1:0] WD = {4{32'hAAAA_AAAA}};

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] i_mem_rdata, d_mem_rdata;
  logic          i_mem_ready, d_mem_ready;
  logic          mem_read, mem_write, mem_ready, grant_d, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_d(grant_d), .busy(busy)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    proc_reset = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    proc_reset = 1;
  endtask

  typedef struct {
    logic          ir, iw, dr, dw;
    logic [AW-1:0] ia, da;
    logic          e_busy, e_gd, e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t vecs[9];

  // Reference model: who owns memory and what transaction it latched
  int            m_owner;   // 0 none, 1 I, 2 D
  bit            m_last_d;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;

  task automatic model_reset();
    m_owner = 0; m_last_d = 0; m_wr = 0; m_addr = '0; m_wd = '0;
  endtask

  task automatic model_edge();
    bit ir, dr;
    int winner;
    ir = i_mem_read | i_mem_write;
    dr = d_mem_read | d_mem_write;
    if (m_owner == 0) begin
      winner = 0;
      if (ir && dr) winner = m_last_d ? 1 : 2;
      else if (dr)  winner = 2;
      else if (ir)  winner = 1;
      if (winner == 1) begin
        m_wr = i_mem_write; m_addr = i_mem_addr; m_wd = i_mem_wdata;
      end else if (winner == 2) begin
        m_wr = d_mem_write; m_addr = d_mem_addr; m_wd = d_mem_wdata;
      end
      if (winner != 0) m_last_d = (winner == 2);
      m_owner = winner;
    end else if (mem_ready) begin
      m_owner = 0;
    end
  endtask

  task automatic model_check_regs();
    chk("rnd_busy",    busy,      m_owner != 0);
    chk("rnd_grant_d", grant_d,   m_owner == 2);
    chk("rnd_read",    mem_read,  m_owner != 0 && !m_wr);
    chk("rnd_write",   mem_write, m_owner != 0 && m_wr);
    chk("rnd_addr",    mem_addr,  m_addr);
    chk("rnd_wdata",   mem_wdata, m_wd);
  endtask

  initial begin
    int rd_cycles, rdy_pulses, found;
    logic [DW-1:0] rv;

    vecs[0] = '{1,0,0,0, 28'h10, 28'h0,  1,0,1,0, 28'h10, WI};
    vecs[1] = '{0,1,0,0, 28'h20, 28'h0,  1,0,0,1, 28'h20, WI};
    vecs[2] = '{0,0,1,0, 28'h0,  28'h30, 1,1,1,0, 28'h30, WD};
    vecs[3] = '{0,0,0,1, 28'h0,  28'h5,  1,1,0,1, 28'h5,  WD};
    vecs[4] = '{0,0,1,1, 28'h0,  28'h6,  1,1,0,1, 28'h6,  WD};
    vecs[5] = '{1,1,0,0, 28'h7,  28'h0,  1,0,0,1, 28'h7,  WI};
    vecs[6] = '{1,0,1,0, 28'h1,  28'h2,  1,1,1,0, 28'h2,  WD};
    vecs[7] = '{0,0,0,0, 28'h1,  28'h2,  0,0,0,0, 28'h0,  '0};
    vecs[8] = '{0,1,0,1, 28'h3,  28'h4,  1,1,0,1, 28'h4,  WD};

    proc_reset = 0;
    clear_inputs();
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_read", mem_read, 0);
    chk("reset_write", mem_write, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_grant_d", grant_d, 0);

    // Directed single transactions, each from a fresh reset
    for (int v = 0; v < 9; v++) begin
      do_reset();
      i_mem_read = vecs[v].ir; i_mem_write = vecs[v].iw;
      d_mem_read = vecs[v].dr; d_mem_write = vecs[v].dw;
      i_mem_addr = vecs[v].ia; d_mem_addr = vecs[v].da;
      i_mem_wdata = WI; d_mem_wdata = WD;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
      chk($sformatf("vec%0d_grant_d", v), grant_d, vecs[v].e_gd);
      chk($sformatf("vec%0d_read", v), mem_read, vecs[v].e_rd);
      chk($sformatf("vec%0d_write", v), mem_write, vecs[v].e_wr);
      chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].e_addr);
      chk($sformatf("vec%0d_wdata", v), mem_wdata, vecs[v].e_wd);
      @(negedge clk);
      i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
      mem_ready = 1; rv = {$urandom, $urandom, $urandom, $urandom}; mem_rdata = rv;
      #1;
      chk($sformatf("vec%0d_i_ready", v), i_mem_ready, vecs[v].e_busy & ~vecs[v].e_gd);
      chk($sformatf("vec%0d_d_ready", v), d_mem_ready, vecs[v].e_busy & vecs[v].e_gd);
      chk($sformatf("vec%0d_i_rdata", v), i_mem_rdata, rv);
      chk($sformatf("vec%0d_d_rdata", v), d_mem_rdata, rv);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle_busy", v), busy, 0);
      chk($sformatf("vec%0d_idle_rw", v), {mem_read, mem_write}, 2'b00);
      @(negedge clk);
      mem_ready = 0;
    end

    // Single I read with 4-cycle memory latency
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h0000010;
    rd_cycles = 0; rdy_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_read && mem_addr == 28'h0000010) rd_cycles++;
      if (k == 3) begin
        mem_ready = 1;
        mem_rdata = 128'h0000_0043_0000_0042_0000_0041_0000_0040;
      end
      #1;
      if (i_mem_ready) rdy_pulses++;
      chk("iread_d_ready", d_mem_ready, 0);
      if (k == 3) chk("iread_rdata", i_mem_rdata, 128'h0000_0043_0000_0042_0000_0041_0000_0040);
    end
    @(negedge clk);
    mem_ready = 0; i_mem_read = 0;
    #1;
    if (i_mem_ready) rdy_pulses++;
    chk("iread_read_cycles", rd_cycles, 4);
    chk("iread_ready_pulses", rdy_pulses, 1);
    chk("iread_busy_fall", busy, 0);
    @(negedge clk);
    chk("iread_stays_idle", busy, 0);

    // Both ports request continuously: grants alternate starting with D
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h100;
    d_mem_read = 1; d_mem_addr = 28'h200;
    for (int t = 0; t < 6; t++) begin
      found = 0;
      for (int w = 0; w < 5 && found == 0; w++) begin
        @(negedge clk);
        if (busy) found = 1;
      end
      chk($sformatf("fair%0d_granted", t), found, 1);
      chk($sformatf("fair%0d_grant_d", t), grant_d, (t % 2) == 0);
      chk($sformatf("fair%0d_addr", t), mem_addr, ((t % 2) == 0) ? 28'h200 : 28'h100);
      chk($sformatf("fair%0d_i_ready_low", t), i_mem_ready, 0);
      mem_ready = 1;
      #1;
      chk($sformatf("fair%0d_i_ready", t), i_mem_ready, (t % 2) == 1);
      chk($sformatf("fair%0d_d_ready", t), d_mem_ready, (t % 2) == 0);
      @(negedge clk);
      mem_ready = 0;
      chk($sformatf("fair%0d_idle", t), busy, 0);
    end
    clear_inputs();

    // Reset in the middle of an I transaction
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h55;
    @(posedge clk); #2;
    mem_ready = 1;
    #1;
    chk("midrst_pre_ready", i_mem_ready, 1);
    proc_reset = 0;
    #1;
    chk("midrst_read", mem_read, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_i_ready", i_mem_ready, 0);
    chk("midrst_addr", mem_addr, 0);
    @(negedge clk);
    proc_reset = 1; i_mem_read = 0; mem_ready = 0;
    d_mem_read = 1; d_mem_addr = 28'h66;
    @(posedge clk); #1;
    chk("midrst_d_grant", grant_d, 1);
    chk("midrst_d_addr", mem_addr, 28'h66);
    chk("midrst_d_read", mem_read, 1);
    @(negedge clk);
    d_mem_read = 0; mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int ri, rd;
      model_check_regs();
      ri = $urandom_range(0, 5);
      rd = $urandom_range(0, 5);
      i_mem_read  = (ri == 1 || ri == 3);
      i_mem_write = (ri == 2 || ri == 3);
      d_mem_read  = (rd == 1 || rd == 3);
      d_mem_write = (rd == 2 || rd == 3);
      i_mem_addr  = AW'($urandom);
      d_mem_addr  = AW'($urandom);
      i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      mem_rdata   = {$urandom, $urandom, $urandom, $urandom};
      mem_ready   = ($urandom_range(0, 2) == 0);
      #1;
      chk("rnd_i_ready", i_mem_ready, m_owner == 1 && mem_ready);
      chk("rnd_d_ready", d_mem_ready, m_owner == 2 && mem_ready);
      chk("rnd_i_rdata", i_mem_rdata, mem_rdata);
      chk("rnd_d_rdata", d_mem_rdata, mem_rdata);
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 128-bit block memory between the instruction cache (I port) and the data cache (D port).
- Sits between the two cache instances and one memory instance.
- Each side uses the same read/write/ready block handshake as a standalone cache-to-memory connection, so either cache connects unmodified.
- Round-robin on simultaneous requests; one outstanding memory transaction at a time.

Parameters:
- ADDR_W, 28, block address width
- DATA_W, 128, block data width

Ports:
- clk  input  1  system clock, rising edge
- proc_reset  input  1  asynchronous, active-low reset (0 = reset)
- i_mem_read  input  1  I-cache block read request
- i_mem_write  input  1  I-cache block write request
- i_mem_addr  input  ADDR_W  I-cache block address
- i_mem_wdata  input  DATA_W  I-cache write block
- i_mem_rdata  output  DATA_W  read block to I-cache
- i_mem_ready  output  1  I-cache transaction complete
- d_mem_read  input  1  D-cache block read request
- d_mem_write  input  1  D-cache block write request
- d_mem_addr  input  ADDR_W  D-cache block address
- d_mem_wdata  input  DATA_W  D-cache write block
- d_mem_rdata  output  DATA_W  read block to D-cache
- d_mem_ready  output  1  D-cache transaction complete
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- mem_addr  output  ADDR_W  memory block address
- mem_wdata  output  DATA_W  memory write block
- mem_rdata  input  DATA_W  memory read block
- mem_ready  input  1  memory transaction complete
- grant_d  output  1  1 = D port owns memory, 0 = I port or idle
- busy  output  1  arbiter not in IDLE

Behaviour:
- Reset (proc_reset=0, asynchronous):
  - state=IDLE; last_grant=I.
  - mem_read, mem_write, mem_addr, mem_wdata, grant_d, busy all 0.
  - i_mem_ready and d_mem_ready are 0.
- States: IDLE, SERVE_I, SERVE_D.
- A port requests when its read or write is 1.
- If read and write are both 1 on one port, write wins and read is ignored for that transaction.
- IDLE, requests sampled at each rising edge:
  - I only -> SERVE_I.
  - D only -> SERVE_D.
  - Both -> the port not equal to last_grant (first tie after reset goes to D).
  - None -> stay IDLE.
- On the grant edge:
  - Latch the winner's addr, wdata and read/write type into registered mem_* outputs, so mem_read or mem_write rises at the grant edge.
  - Set last_grant to the winner; set grant_d and busy.
  - Latency: request present at edge N -> memory request visible after edge N.
- SERVE_x, while mem_ready=0:
  - Hold the latched mem_* outputs; requester inputs are not re-sampled.
  - The other port waits with no ready.
- SERVE_x, when mem_ready=1:
  - Drive x_mem_ready=1 combinationally in that same cycle.
  - x_mem_rdata = mem_rdata.
  - At the next edge: clear mem_read/mem_write, return to IDLE, busy=0, grant_d=0.
- Minimum transaction time is 2 cycles; IDLE always lasts at least 1 cycle between transactions.
  - The released cache has that cycle to drop its request.
  - The waiting port is granted at the end of the IDLE cycle.
- Ready gating:
  - The non-granted port's ready is always 0.
  - Any mem_ready while in IDLE is ignored and never forwarded.
- rdata routing: both x_mem_rdata outputs mirror mem_rdata continuously; only ready qualifies the data.
- Withdrawal: a request deasserted before it is granted is dropped with no side effect.
- Starvation bound: with both ports requesting continuously, grants alternate D, I, D, I...
- Reset mid-transaction: outputs drop to 0 immediately, state goes to IDLE, and the pending transaction is abandoned. Caches are reset by the same reset.

Test Plan:
- Single I read: i_mem_read=1, addr=0x0000010, memory ready after 4 cycles with rdata=0x...0043_0042_0041_0040 -> mem_read=1 and mem_addr=0x0000010 for 4 cycles; i_mem_ready=1 for exactly 1 cycle with that data; d_mem_ready stays 0; busy falls 1 cycle later.
- Single D write: d_mem_write=1, addr=0x5, wdata=0xAAAA...AAAA -> mem_write=1 with addr 0x5 and the data; grant_d=1 throughout; d_mem_ready pulses once; mem_read never 1.
- Simultaneous after reset: I read 0x1 and D read 0x2 asserted on the same edge -> D served first (mem_addr=0x2), then 1 IDLE cycle, then I (mem_addr=0x1).
- Back-to-back fairness: both ports hold requests for 6 transactions -> grant sequence D,I,D,I,D,I; each port's ready only during its own grant.
- Collision on one port: d_mem_read=1 and d_mem_write=1 together -> memory sees write only; a stray mem_ready in IDLE produces no ready on either port.
- Reset mid-transaction: proc_reset=0 while in SERVE_I -> mem_read=0, busy=0, i_mem_ready=0 without a clock edge; after release, a new D request is granted normally.
